// File: rtl/ocs_ctrl_pkg.sv
// Shared OCS control-path definitions: frame subtype codes, broadcast MAC,
// RX parser state encoding. The TX-side frame builders use the same codes.
package ocs_ctrl_pkg;

   localparam logic [7:0]  ST_SLAVE_TS  = 8'h01;
   localparam logic [7:0]  ST_RETURN_TS = 8'h02;
   localparam logic [7:0]  ST_STD_TIME  = 8'h03;
   localparam logic [7:0]  ST_SYN_START = 8'h04;
   localparam logic [7:0]  ST_SYN_STOP  = 8'h05;

   localparam logic [47:0] BCAST_MAC    = 48'hFFFF_FFFF_FFFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_PAYLOAD,
      S_TAIL,
      S_DROP
   } rx_state_e;

   // True for the subtypes the parser knows how to commit.
   function automatic logic subtype_ok(input logic [7:0] st);
      return (st >= ST_SLAVE_TS) && (st <= ST_SYN_STOP);
   endfunction

endpackage

// File: rtl/ocs_ctrl_rx_parser_if.sv
// AXI-stream beat bundle from the 10G MAC RX into the control parser.
// No tready: the consumer never back-pressures.
interface ocs_ctrl_rx_parser_if;
   logic        tvalid;
   logic [63:0] tdata;
   logic        tlast;
   logic [7:0]  tkeep;
   logic        tuser;

   modport master (output tvalid, tdata, tlast, tkeep, tuser);
   modport slave  (input  tvalid, tdata, tlast, tkeep, tuser);
endinterface

// File: rtl/ocs_ctrl_rx_parser.sv
// OCS control RX parser: filters MAC RX frames by destination MAC and
// EtherType, then commits timestamp / standard time / slot id / sync-start
// results one cycle after the last beat of a good frame.
module ocs_ctrl_rx_parser
   import ocs_ctrl_pkg::*;
#(
   parameter logic [15:0] P_SLOT_ID_TYPE = 16'hff03,
   parameter logic [47:0] P_MY_MAC       = 48'h8D_BC_5C_4A_1A_1F,
   parameter logic [7:0]  P_MAX_BEATS    = 8'd16
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   ocs_ctrl_rx_parser_if.slave        s_ctrl_rx_axis,
   output logic [63:0]                o_recv_time_stamp,
   output logic                       o_recv_ts_valid,
   output logic [63:0]                o_recv_return_ts,
   output logic                       o_recv_return_valid,
   output logic [63:0]                o_recv_std_time,
   output logic                       o_recv_std_valid,
   output logic [7:0]                 o_cur_slot_id,
   output logic                       o_syn_start,
   output logic [15:0]                o_drop_cnt
);

   rx_state_e   state;
   logic [7:0]  beat_cnt;     // beats already consumed in the current frame
   logic [7:0]  beat_num;     // 1-based index of the beat on the bus now
   logic [7:0]  subtype_q;
   logic [7:0]  slot_q;
   logic [63:0] payload_q;

   logic        fin;
   logic        dst_ok;
   logic        hdr_ok;
   logic        over_len;
   logic        commit;
   logic        drop;
   logic [63:0] commit_data;

   assign beat_num = (beat_cnt == 8'hFF) ? 8'hFF : beat_cnt + 8'd1;
   assign over_len = beat_num > P_MAX_BEATS;
   assign fin      = s_ctrl_rx_axis.tvalid & s_ctrl_rx_axis.tlast;
   assign dst_ok   = (s_ctrl_rx_axis.tdata[63:16] == P_MY_MAC) ||
                     (s_ctrl_rx_axis.tdata[63:16] == BCAST_MAC);
   assign hdr_ok   = (s_ctrl_rx_axis.tdata[31:16] == P_SLOT_ID_TYPE) &&
                     subtype_ok(s_ctrl_rx_axis.tdata[15:8]);

   // A 3-beat frame ends on the payload beat itself, so every payload byte
   // must be present there; padding beats carry nothing, so their tkeep is moot.
   assign commit = fin && !s_ctrl_rx_axis.tuser &&
                   (((state == S_PAYLOAD) && (s_ctrl_rx_axis.tkeep == 8'hFF)) ||
                    ((state == S_TAIL) && !over_len));
   // Every other frame end (runt, bad header, error, over-length) is a discard.
   assign drop   = fin && !commit;

   assign commit_data = (state == S_PAYLOAD) ? s_ctrl_rx_axis.tdata : payload_q;

   // Frame FSM, header capture and registered result outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state               <= S_IDLE;
         beat_cnt            <= 8'd0;
         subtype_q           <= 8'd0;
         slot_q              <= 8'd0;
         payload_q           <= 64'd0;
         o_recv_time_stamp   <= 64'd0;
         o_recv_ts_valid     <= 1'b0;
         o_recv_return_ts    <= 64'd0;
         o_recv_return_valid <= 1'b0;
         o_recv_std_time     <= 64'd0;
         o_recv_std_valid    <= 1'b0;
         o_cur_slot_id       <= 8'd0;
         o_syn_start         <= 1'b0;
         o_drop_cnt          <= 16'd0;
      end else begin
         o_recv_ts_valid     <= 1'b0;
         o_recv_return_valid <= 1'b0;
         o_recv_std_valid    <= 1'b0;

         if (s_ctrl_rx_axis.tvalid) begin
            beat_cnt <= s_ctrl_rx_axis.tlast ? 8'd0 : beat_num;
            if (fin) begin
               state <= S_IDLE;
            end else begin
               case (state)
                  S_IDLE:    state <= dst_ok ? S_HDR : S_DROP;
                  S_HDR:     state <= hdr_ok ? S_PAYLOAD : S_DROP;
                  S_PAYLOAD: state <= S_TAIL;
                  S_TAIL:    state <= over_len ? S_DROP : S_TAIL;
                  default:   state <= S_DROP;
               endcase
            end
            if (state == S_HDR) begin
               subtype_q <= s_ctrl_rx_axis.tdata[15:8];
               slot_q    <= s_ctrl_rx_axis.tdata[7:0];
            end
            if (state == S_PAYLOAD)
               payload_q <= s_ctrl_rx_axis.tdata;
         end

         if (drop && (o_drop_cnt != 16'hFFFF))
            o_drop_cnt <= o_drop_cnt + 16'd1;

         if (commit) begin
            o_cur_slot_id <= slot_q;
            case (subtype_q)
               ST_SLAVE_TS: begin
                  o_recv_time_stamp <= commit_data;
                  o_recv_ts_valid   <= 1'b1;
               end
               ST_RETURN_TS: begin
                  o_recv_return_ts    <= commit_data;
                  o_recv_return_valid <= 1'b1;
               end
               ST_STD_TIME: begin
                  o_recv_std_time  <= commit_data;
                  o_recv_std_valid <= 1'b1;
               end
               ST_SYN_START: o_syn_start <= 1'b1;
               ST_SYN_STOP:  o_syn_start <= 1'b0;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ocs_ctrl_rx_parser.sv
// Directed bench for the OCS control RX parser. Stimulus pushes the expected
// result pulse into a queue; a negedge monitor pops and compares on each pulse.
module tb_ocs_ctrl_rx_parser;
   import ocs_ctrl_pkg::*;

   localparam logic [47:0] MY_MAC  = 48'h8D_BC_5C_4A_1A_1F;
   localparam logic [47:0] SRC_MAC = 48'h0200_0000_00AA;
   localparam logic [15:0] CTRL_TY = 16'hff03;

   typedef struct {
      int          kind;   // 1 ts, 2 return, 3 std time
      logic [63:0] data;
      logic [7:0]  slot;
   } exp_t;

   logic i_clk = 1'b0;
   logic i_rst;

   logic [63:0] o_recv_time_stamp, o_recv_return_ts, o_recv_std_time;
   logic        o_recv_ts_valid, o_recv_return_valid, o_recv_std_valid;
   logic [7:0]  o_cur_slot_id;
   logic        o_syn_start;
   logic [15:0] o_drop_cnt;

   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];

   ocs_ctrl_rx_parser_if rx_if();

   ocs_ctrl_rx_parser dut (
      .i_clk               (i_clk),
      .i_rst               (i_rst),
      .s_ctrl_rx_axis      (rx_if),
      .o_recv_time_stamp   (o_recv_time_stamp),
      .o_recv_ts_valid     (o_recv_ts_valid),
      .o_recv_return_ts    (o_recv_return_ts),
      .o_recv_return_valid (o_recv_return_valid),
      .o_recv_std_time     (o_recv_std_time),
      .o_recv_std_valid    (o_recv_std_valid),
      .o_cur_slot_id       (o_cur_slot_id),
      .o_syn_start         (o_syn_start),
      .o_drop_cnt          (o_drop_cnt)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic push(input int kind, input logic [63:0] data, input logic [7:0] slot);
      exp_t e;
      e.kind = kind; e.data = data; e.slot = slot;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      rx_if.tvalid = 1'b0;
      repeat (n) begin @(posedge i_clk); #1; end
   endtask

   // One frame; gap_len idle cycles inserted before beat gap_at, reset raised on beat rst_at.
   task automatic send_frame(input logic [47:0] dst, input logic [15:0] ety,
                             input logic [7:0] st, input logic [7:0] slot,
                             input logic [63:0] pay, input int nb, input logic user,
                             input int gap_at, input int gap_len, input int rst_at);
      logic [63:0] d;
      for (int b = 0; b < nb; b++) begin
         if (b == gap_at) idle(gap_len);
         case (b)
            0:       d = {dst, SRC_MAC[47:32]};
            1:       d = {SRC_MAC[31:0], ety, st, slot};
            2:       d = pay;
            default: d = 64'hDEAD_0000 + 64'(b);
         endcase
         if (b == rst_at) i_rst = 1'b1;
         rx_if.tvalid = 1'b1;
         rx_if.tdata  = d;
         rx_if.tlast  = (b == nb - 1);
         rx_if.tuser  = (b == nb - 1) ? user : 1'b0;
         rx_if.tkeep  = 8'hFF;
         @(posedge i_clk); #1;
      end
      rx_if.tvalid = 1'b0;
      rx_if.tlast  = 1'b0;
      rx_if.tuser  = 1'b0;
   endtask

   // Monitor: every result pulse must match the head of the expected queue.
   int          mon_kind;
   logic [63:0] mon_data;
   exp_t        mon_e;
   initial begin
      forever begin
         @(negedge i_clk);
         if (o_recv_ts_valid | o_recv_return_valid | o_recv_std_valid) begin
            mon_kind = o_recv_ts_valid ? 1 : (o_recv_return_valid ? 2 : 3);
            mon_data = o_recv_ts_valid ? o_recv_time_stamp :
                       (o_recv_return_valid ? o_recv_return_ts : o_recv_std_time);
            checks++;
            if ((32'(o_recv_ts_valid) + 32'(o_recv_return_valid) + 32'(o_recv_std_valid)) > 1) begin
               errors++;
               $display("FAIL multi_pulse ts=%b ret=%b std=%b exp=one", o_recv_ts_valid,
                        o_recv_return_valid, o_recv_std_valid);
            end else if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse kind=%0d data=%h exp=none", mon_kind, mon_data);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_kind != mon_e.kind || mon_data !== mon_e.data || o_cur_slot_id !== mon_e.slot) begin
                  errors++;
                  $display("FAIL pulse got kind=%0d data=%h slot=%h exp kind=%0d data=%h slot=%h",
                           mon_kind, mon_data, o_cur_slot_id, mon_e.kind, mon_e.data, mon_e.slot);
               end
            end
         end
      end
   end

   initial begin
      i_rst = 1'b1;
      rx_if.tvalid = 1'b0; rx_if.tdata = 64'd0; rx_if.tlast = 1'b0;
      rx_if.tkeep = 8'h00; rx_if.tuser = 1'b0;
      repeat (3) begin @(posedge i_clk); #1; end
      check("rst_ts",      o_recv_time_stamp, 64'd0);
      check("rst_ts_vld",  64'(o_recv_ts_valid), 64'd0);
      check("rst_drop",    64'(o_drop_cnt), 64'd0);
      check("rst_syn",     64'(o_syn_start), 64'd0);
      check("rst_slot",    64'(o_cur_slot_id), 64'd0);
      i_rst = 1'b0;
      idle(2);

      // 1) minimal 3-beat slave timestamp, exact 1-cycle latency, 1-cycle pulse
      push(1, 64'h1234, 8'h11);
      send_frame(MY_MAC, CTRL_TY, ST_SLAVE_TS, 8'h11, 64'h1234, 3, 1'b0, -1, 0, -1);
      check("t1_latency", 64'(o_recv_ts_valid), 64'd1);
      check("t1_ts",      o_recv_time_stamp, 64'h1234);
      @(posedge i_clk); #1;
      check("t1_pulse_w", 64'(o_recv_ts_valid), 64'd0);
      idle(2);

      // 2) broadcast std time, 8 beats, 2-cycle gap after beat1
      push(3, 64'hABCD, 8'h5A);
      send_frame(BCAST_MAC, CTRL_TY, ST_STD_TIME, 8'h5A, 64'hABCD, 8, 1'b0, 2, 2, -1);
      check("t2_std_vld", 64'(o_recv_std_valid), 64'd1);
      check("t2_slot",    64'(o_cur_slot_id), 64'h5A);
      idle(2);

      // 3) wrong MAC, wrong EtherType
      send_frame(48'h1122_3344_5566, CTRL_TY, ST_SLAVE_TS, 8'h31, 64'h3131, 4, 1'b0, -1, 0, -1);
      send_frame(MY_MAC, 16'h0800, ST_SLAVE_TS, 8'h32, 64'h3232, 4, 1'b0, -1, 0, -1);
      idle(2);
      check("t3_drop", 64'(o_drop_cnt), 64'd2);

      // 4) MAC error on tlast, then runt ending on beat1
      send_frame(MY_MAC, CTRL_TY, ST_RETURN_TS, 8'h22, 64'h9999, 3, 1'b1, -1, 0, -1);
      send_frame(MY_MAC, CTRL_TY, ST_RETURN_TS, 8'h23, 64'h8888, 2, 1'b0, -1, 0, -1);
      idle(2);
      check("t4_drop",   64'(o_drop_cnt), 64'd4);
      check("t4_ret_ts", o_recv_return_ts, 64'd0);
      check("t4_slot",   64'(o_cur_slot_id), 64'h5A);

      // 5) sync start then stop, back-to-back
      send_frame(MY_MAC, CTRL_TY, ST_SYN_START, 8'h44, 64'd0, 3, 1'b0, -1, 0, -1);
      check("t5_syn_set", 64'(o_syn_start), 64'd1);
      check("t5_slot_a",  64'(o_cur_slot_id), 64'h44);
      send_frame(MY_MAC, CTRL_TY, ST_SYN_STOP, 8'h45, 64'd0, 4, 1'b0, -1, 0, -1);
      check("t5_syn_clr", 64'(o_syn_start), 64'd0);
      check("t5_slot_b",  64'(o_cur_slot_id), 64'h45);
      idle(2);

      // 7) length boundary: 16 beats accepted, 17 beats dropped
      push(1, 64'h1616, 8'h16);
      send_frame(MY_MAC, CTRL_TY, ST_SLAVE_TS, 8'h16, 64'h1616, 16, 1'b0, -1, 0, -1);
      idle(2);
      send_frame(MY_MAC, CTRL_TY, ST_SLAVE_TS, 8'h17, 64'h1717, 17, 1'b0, -1, 0, -1);
      idle(2);
      check("t7_drop", 64'(o_drop_cnt), 64'd5);
      check("t7_ts",   o_recv_time_stamp, 64'h1616);
      check("t7_slot", 64'(o_cur_slot_id), 64'h16);

      // 6) reset on beat2 of a slave-ts frame, then a good return-ts frame
      send_frame(MY_MAC, CTRL_TY, ST_SLAVE_TS, 8'h61, 64'h6161, 3, 1'b0, -1, 0, 2);
      check("t6_rst_drop", 64'(o_drop_cnt), 64'd0);
      check("t6_rst_ts",   o_recv_time_stamp, 64'd0);
      check("t6_rst_slot", 64'(o_cur_slot_id), 64'd0);
      check("t6_rst_vld",  64'(o_recv_ts_valid), 64'd0);
      i_rst = 1'b0;
      idle(1);
      push(2, 64'h6262, 8'h62);
      send_frame(MY_MAC, CTRL_TY, ST_RETURN_TS, 8'h62, 64'h6262, 3, 1'b0, -1, 0, -1);
      idle(3);
      check("t6_ret_ts", o_recv_return_ts, 64'h6262);
      check("t6_ts",     o_recv_time_stamp, 64'd0);
      check("t6_drop",   64'(o_drop_cnt), 64'd0);

      check("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
